// File: rtl/workload_sequencer.sv
// rtl/workload_sequencer.sv - single-workload read/write sequencer for an MMIO-started accelerator
//
// Purpose:
//   After an accepted START strobe, issues num_items cache-line read requests
//   from read_base, bounded to MAX_OUTSTANDING reads in flight. Datapath
//   results are passed straight through as write requests to write_base.
//   Read/write completions are counted. A one-cycle finish pulse marks the end
//   of the workload, whether it completed normally or stopped on a read error.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_mmio_rstb                   soft reset, active-low, same effect as i_rst
//   i_start_pls                   one-cycle START strobe
//   i_read_base_addr              source base, latched on accepted start
//   i_write_base_addr             destination base, latched on accepted start
//   i_num_items_to_process        item count N, latched on accepted start
//   o_rd_req_valid/i_rd_req_ready read request handshake (addr, tag)
//   i_rd_rsp_valid, i_rd_rsp_err  read completion strobe and error flag
//   i_dp_result_valid/o_dp_result_ready  datapath result handshake
//   o_wr_req_valid/i_wr_req_ready write request handshake (addr, tag)
//   i_wr_rsp_valid                write completion strobe
//   o_num_reads_read_active       read completions this workload
//   o_num_reads_written_active    write completions this workload
//   o_busy                        high in RUN or DRAIN
//   o_finish                      one-cycle completion pulse
//   o_error                       sticky read-error flag, cleared on accepted start

module workload_sequencer #(
  parameter int ITEM_BYTES      = 128,
  parameter int MAX_OUTSTANDING = 16,
  parameter int TAG_W           = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_mmio_rstb,
  input  logic             i_start_pls,
  input  logic [63:0]      i_read_base_addr,
  input  logic [63:0]      i_write_base_addr,
  input  logic [31:0]      i_num_items_to_process,
  output logic             o_rd_req_valid,
  input  logic             i_rd_req_ready,
  output logic [63:0]      o_rd_req_addr,
  output logic [TAG_W-1:0] o_rd_req_tag,
  input  logic             i_rd_rsp_valid,
  input  logic             i_rd_rsp_err,
  input  logic             i_dp_result_valid,
  output logic             o_dp_result_ready,
  output logic             o_wr_req_valid,
  input  logic             i_wr_req_ready,
  output logic [63:0]      o_wr_req_addr,
  output logic [TAG_W-1:0] o_wr_req_tag,
  input  logic             i_wr_rsp_valid,
  output logic [31:0]      o_num_reads_read_active,
  output logic [31:0]      o_num_reads_written_active,
  output logic             o_busy,
  output logic             o_finish,
  output logic             o_error
);

  localparam int          ITEM_SHIFT = $clog2(ITEM_BYTES);
  localparam int          SLOT_W     = $clog2(MAX_OUTSTANDING);
  localparam logic [31:0] MAX_OUT    = 32'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic [63:0] r_rd_base;
  logic [63:0] r_wr_base;
  logic [31:0] r_num_items;
  logic [31:0] r_rd_issued;
  logic [31:0] r_rd_done;
  logic [31:0] r_wr_issued;
  logic [31:0] r_wr_done;
  logic        r_error;
  logic        r_zero_finish;

  logic              w_rst;
  logic              w_busy;
  logic              w_rd_err;
  logic [31:0]       w_outstanding;
  logic              w_rd_valid;
  logic              w_rd_accept;
  logic              w_wr_accept;
  logic              w_start_ok;
  logic              w_start_zero;
  logic              w_last_read;
  logic [SLOT_W-1:0] w_rd_slot;

  // Either reset source clears everything and abandons the workload.
  assign w_rst = i_rst | ~i_mmio_rstb;

  assign w_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_rd_err     = i_rd_rsp_valid & i_rd_rsp_err;
  assign w_start_ok   = (r_state == S_IDLE) && i_start_pls && (i_num_items_to_process != 32'd0);
  assign w_start_zero = (r_state == S_IDLE) && i_start_pls && (i_num_items_to_process == 32'd0);

  // Credit check uses registered counts only: a completion frees its credit
  // for the cycle after it arrives. A read error stops issue immediately.
  assign w_outstanding = r_rd_issued - r_rd_done;
  assign w_rd_valid    = (r_state == S_RUN) && (r_rd_issued < r_num_items) &&
                         (w_outstanding < MAX_OUT) && !w_rd_err;
  assign w_rd_accept   = w_rd_valid & i_rd_req_ready;
  assign w_last_read   = w_rd_accept && ((r_rd_issued + 32'd1) == r_num_items);

  // Results pass straight through to the write port while a workload is active.
  assign w_wr_accept = i_dp_result_valid & i_wr_req_ready & w_busy;

  // Addresses and tags derive from registered counters, so they stay stable
  // while a request is stalled.
  assign w_rd_slot = r_rd_issued[SLOT_W-1:0];

  assign o_rd_req_valid    = w_rd_valid;
  assign o_rd_req_addr     = r_rd_base + ({32'd0, r_rd_issued} << ITEM_SHIFT);
  assign o_rd_req_tag      = {1'b0, (TAG_W-1)'(w_rd_slot)};
  assign o_dp_result_ready = i_wr_req_ready & w_busy;
  assign o_wr_req_valid    = i_dp_result_valid & w_busy;
  assign o_wr_req_addr     = r_wr_base + ({32'd0, r_wr_issued} << ITEM_SHIFT);
  // Tag reads as zero when no workload is active so reset leaves every output at 0.
  assign o_wr_req_tag      = w_busy ? {1'b1, r_wr_issued[TAG_W-2:0]} : '0;

  assign o_num_reads_read_active    = r_rd_done;
  assign o_num_reads_written_active = r_wr_done;
  assign o_error                    = r_error;

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_busy       = w_busy;
    // A zero-item start completes at once without ever leaving IDLE.
    o_finish     = (r_state == S_DONE) || r_zero_finish;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_rd_err) begin
          w_next_state = S_DONE;
        end else if (w_last_read) begin
          w_next_state = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_rd_err || (r_wr_done == r_num_items)) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_rst) begin
      r_rd_base     <= '0;
      r_wr_base     <= '0;
      r_num_items   <= '0;
      r_rd_issued   <= '0;
      r_rd_done     <= '0;
      r_wr_issued   <= '0;
      r_wr_done     <= '0;
      r_error       <= 1'b0;
      r_zero_finish <= 1'b0;
    end else begin
      r_zero_finish <= w_start_zero;
      if (w_start_ok) begin
        r_rd_base   <= i_read_base_addr;
        r_wr_base   <= i_write_base_addr;
        r_num_items <= i_num_items_to_process;
        r_rd_issued <= '0;
        r_rd_done   <= '0;
        r_wr_issued <= '0;
        r_wr_done   <= '0;
        r_error     <= 1'b0;
      end else begin
        if (w_rd_accept) begin
          r_rd_issued <= r_rd_issued + 32'd1;
        end
        if (w_wr_accept) begin
          r_wr_issued <= r_wr_issued + 32'd1;
        end
        // Completions outside RUN/DRAIN belong to no live workload.
        if (w_busy && i_rd_rsp_valid) begin
          r_rd_done <= r_rd_done + 32'd1;
        end
        if (w_busy && i_wr_rsp_valid) begin
          r_wr_done <= r_wr_done + 32'd1;
        end
        if (w_busy && w_rd_err) begin
          r_error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_workload_sequencer.sv
// tb/tb_workload_sequencer.sv - self-checking bench for workload_sequencer
module tb_workload_sequencer;

  logic        clk;
  logic        rst;
  logic        mmio_rstb;
  logic        start;
  logic [63:0] rbase;
  logic [63:0] wbase;
  logic [31:0] nitems;
  logic        rd_ready;
  logic        rsp_valid;
  logic        rsp_err;
  logic        dp_valid;
  logic        wr_ready;
  logic        wr_rsp;
  logic        o_rd_req_valid;
  logic [63:0] o_rd_req_addr;
  logic [7:0]  o_rd_req_tag;
  logic        o_dp_result_ready;
  logic        o_wr_req_valid;
  logic [63:0] o_wr_req_addr;
  logic [7:0]  o_wr_req_tag;
  logic [31:0] o_reads;
  logic [31:0] o_writes;
  logic        o_busy;
  logic        o_finish;
  logic        o_error;

  workload_sequencer dut (
    .i_clk                      (clk),
    .i_rst                      (rst),
    .i_mmio_rstb                (mmio_rstb),
    .i_start_pls                (start),
    .i_read_base_addr           (rbase),
    .i_write_base_addr          (wbase),
    .i_num_items_to_process     (nitems),
    .o_rd_req_valid             (o_rd_req_valid),
    .i_rd_req_ready             (rd_ready),
    .o_rd_req_addr              (o_rd_req_addr),
    .o_rd_req_tag               (o_rd_req_tag),
    .i_rd_rsp_valid             (rsp_valid),
    .i_rd_rsp_err               (rsp_err),
    .i_dp_result_valid          (dp_valid),
    .o_dp_result_ready          (o_dp_result_ready),
    .o_wr_req_valid             (o_wr_req_valid),
    .i_wr_req_ready             (wr_ready),
    .o_wr_req_addr              (o_wr_req_addr),
    .o_wr_req_tag               (o_wr_req_tag),
    .i_wr_rsp_valid             (wr_rsp),
    .o_num_reads_read_active    (o_reads),
    .o_num_reads_written_active (o_writes),
    .o_busy                     (o_busy),
    .o_finish                   (o_finish),
    .o_error                    (o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp;
  int n_fail;
  bit cmp_on;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 issuing reads, 2 waiting for writes, 3 completing
  int unsigned m_ph, m_n, m_ri, m_rd, m_wi, m_wd;
  logic [63:0] m_rb, m_wb;
  bit          m_err, m_zf;

  function automatic bit e_busy();
    return (m_ph == 1) || (m_ph == 2);
  endfunction

  function automatic bit e_rv();
    return (m_ph == 1) && (m_ri < m_n) && ((m_ri - m_rd) < 16) && !(rsp_valid && rsp_err);
  endfunction

  initial begin : model
    bit          acc;
    bit          zf_n;
    int unsigned wd_old;
    m_ph = 0; m_n = 0; m_ri = 0; m_rd = 0; m_wi = 0; m_wd = 0;
    m_rb = 0; m_wb = 0; m_err = 0; m_zf = 0;
    forever begin
      @(posedge clk);
      if (rst || !mmio_rstb) begin
        m_ph = 0; m_n = 0; m_ri = 0; m_rd = 0; m_wi = 0; m_wd = 0;
        m_rb = 0; m_wb = 0; m_err = 0; m_zf = 0;
      end else begin
        zf_n = (m_ph == 0) && start && (nitems == 0);
        if (m_ph == 0) begin
          if (start && nitems != 0) begin
            m_rb = rbase; m_wb = wbase; m_n = nitems;
            m_ri = 0; m_rd = 0; m_wi = 0; m_wd = 0; m_err = 0;
            m_ph = 1;
          end
        end else if (m_ph == 3) begin
          m_ph = 0;
        end else begin
          acc    = e_rv() && rd_ready;
          wd_old = m_wd;
          if (acc) m_ri++;
          if (dp_valid && wr_ready) m_wi++;
          if (rsp_valid) m_rd++;
          if (wr_rsp) m_wd++;
          if (rsp_valid && rsp_err) begin
            m_err = 1;
            m_ph  = 3;
          end else if (m_ph == 1 && acc && m_ri == m_n) begin
            m_ph = 2;
          end else if (m_ph == 2 && wd_old == m_n) begin
            m_ph = 3;
          end
        end
        m_zf = zf_n;
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_on) begin
        chk("busy", o_busy, e_busy());
        chk("rd_valid", o_rd_req_valid, e_rv());
        chk("rd_addr", o_rd_req_addr, m_rb + 64'(m_ri) * 128);
        chk("rd_tag", o_rd_req_tag, m_ri % 16);
        chk("wr_valid", o_wr_req_valid, dp_valid && e_busy());
        chk("dp_ready", o_dp_result_ready, wr_ready && e_busy());
        chk("wr_addr", o_wr_req_addr, m_wb + 64'(m_wi) * 128);
        chk("wr_tag", o_wr_req_tag, e_busy() ? (64'h80 | (m_wi & 32'h7f)) : 64'h0);
        chk("reads_cnt", o_reads, m_rd);
        chk("writes_cnt", o_writes, m_wd);
        chk("finish", o_finish, (m_ph == 3) || m_zf);
        chk("error", o_error, m_err);
      end
    end
  end

  // ---------------- memory / datapath responder ----------------
  int          cyc;
  int          rq[$];
  int          resq[$];
  int          wq[$];
  int          dp_pend;
  int          rsp_n;
  int          err_idx;
  bit          auto_rsp;
  int          force_req;
  int          force_done;
  int          n_rd_acc;
  logic [63:0] rd_addr_log[$];
  logic [7:0]  rd_tag_log[$];
  logic [63:0] wr_addr_log[$];
  logic [7:0]  wr_tag_log[$];

  initial begin
    cyc = 0; dp_pend = 0; rsp_n = 0; force_done = 0; n_rd_acc = 0;
    rsp_valid = 0; rsp_err = 0; dp_valid = 0; wr_rsp = 0;
    forever begin
      @(negedge clk);
      if (rst || !mmio_rstb) begin
        rq = {}; resq = {}; wq = {}; dp_pend = 0; rsp_n = 0; n_rd_acc = 0;
        rd_addr_log = {}; rd_tag_log = {}; wr_addr_log = {}; wr_tag_log = {};
      end else begin
        if (o_rd_req_valid === 1'b1 && rd_ready) begin
          n_rd_acc++;
          rd_addr_log.push_back(o_rd_req_addr);
          rd_tag_log.push_back(o_rd_req_tag);
          if (auto_rsp) rq.push_back(cyc + 3);
        end
        if (o_wr_req_valid === 1'b1 && wr_ready) begin
          wr_addr_log.push_back(o_wr_req_addr);
          wr_tag_log.push_back(o_wr_req_tag);
          wq.push_back(cyc + 2);
          dp_pend--;
        end
      end
      @(posedge clk);
      cyc++;
      #1;
      rsp_valid = 0;
      rsp_err   = 0;
      if ((rq.size() > 0 && rq[0] == cyc) || force_req != force_done) begin
        if (rq.size() > 0 && rq[0] == cyc) void'(rq.pop_front());
        else force_done++;
        rsp_n++;
        rsp_valid = 1;
        rsp_err   = (rsp_n == err_idx);
        resq.push_back(cyc + 2);
      end
      if (resq.size() > 0 && resq[0] == cyc) begin
        void'(resq.pop_front());
        dp_pend++;
      end
      dp_valid = (dp_pend > 0);
      wr_rsp   = 0;
      if (wq.size() > 0 && wq[0] == cyc) begin
        void'(wq.pop_front());
        wr_rsp = 1;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clean_reset();
    rst = 1;
    tick();
    rst = 0;
    tick();
  endtask

  task automatic do_start(input logic [63:0] rb, input logic [63:0] wb, input logic [31:0] n);
    rbase  = rb;
    wbase  = wb;
    nitems = n;
    start  = 1;
    tick();
    start  = 0;
  endtask

  task automatic wait_finish(input int budget, input string nm);
    bit ok;
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (o_finish === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: finish not seen within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cmp_on = 0;
    rst = 1; mmio_rstb = 1; start = 0; rbase = 0; wbase = 0; nitems = 0;
    rd_ready = 1; wr_ready = 1; err_idx = 0; auto_rsp = 1; force_req = 0;
    tick();
    cmp_on = 1;

    // Reset state: every output is zero.
    @(negedge clk);
    chk("rst_rd_valid", o_rd_req_valid, 0);
    chk("rst_rd_addr", o_rd_req_addr, 0);
    chk("rst_wr_tag", o_wr_req_tag, 0);
    chk("rst_busy_fin_err", {o_busy, o_finish, o_error}, 0);
    tick();
    rst = 0;
    tick();

    // N=4, ready always high, 3-cycle read latency, result 2 cycles after rsp.
    clean_reset();
    do_start(64'h1000, 64'h8000, 4);
    wait_finish(100, "t1_finish");
    chk("t1_reads", o_reads, 4);
    chk("t1_writes", o_writes, 4);
    chk("t1_nrd", rd_addr_log.size(), 4);
    chk("t1_nwr", wr_tag_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_rd_addr", (i < rd_addr_log.size()) ? rd_addr_log[i] : 64'hdead, 64'h1000 + 64'(i) * 64'h80);
      chk("t1_rd_tag", (i < rd_tag_log.size()) ? rd_tag_log[i] : 8'hff, 64'(i));
      chk("t1_wr_tag", (i < wr_tag_log.size()) ? wr_tag_log[i] : 8'hff, 64'h80 + 64'(i));
      chk("t1_wr_addr", (i < wr_addr_log.size()) ? wr_addr_log[i] : 64'hdead, 64'h8000 + 64'(i) * 64'h80);
    end
    @(negedge clk);
    chk("t1_finish_width", o_finish, 0);
    chk("t1_idle_busy", o_busy, 0);
    tick();

    // N=0: finish on the next cycle only, never busy.
    clean_reset();
    do_start(64'h0, 64'h0, 0);
    @(negedge clk);
    chk("t4_finish", o_finish, 1);
    chk("t4_busy", o_busy, 0);
    tick();
    @(negedge clk);
    chk("t4_finish_gone", o_finish, 0);
    chk("t4_busy2", o_busy, 0);
    tick();

    // Read request stalled for 5 cycles: addr/tag stable, no duplicate issue.
    clean_reset();
    rd_ready = 0;
    do_start(64'h2000, 64'h9000, 3);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_stall_valid", o_rd_req_valid, 1);
      chk("t3_stall_addr", o_rd_req_addr, 64'h2000);
      chk("t3_stall_tag", o_rd_req_tag, 0);
      tick();
    end
    chk("t3_no_issue", n_rd_acc, 0);
    rd_ready = 1;
    tick();
    chk("t3_one_issue", n_rd_acc, 1);
    @(negedge clk);
    chk("t3_next_addr", o_rd_req_addr, 64'h2080);
    chk("t3_next_tag", o_rd_req_tag, 1);
    wait_finish(100, "t3_finish");
    chk("t3_reads", o_reads, 3);
    tick();

    // Start mid-RUN is ignored.
    clean_reset();
    do_start(64'h3000, 64'hA000, 8);
    repeat (3) tick();
    do_start(64'h5000, 64'hB000, 2);
    wait_finish(200, "t5_finish");
    chk("t5_reads", o_reads, 8);
    chk("t5_writes", o_writes, 8);
    chk("t5_last_rd", (rd_addr_log.size() == 8) ? rd_addr_log[7] : 64'hdead, 64'h3380);
    chk("t5_last_wr", (wr_addr_log.size() == 8) ? wr_addr_log[7] : 64'hdead, 64'hA380);
    tick();

    // Error on the 3rd read response.
    clean_reset();
    err_idx = 3;
    do_start(64'h4000, 64'hC000, 6);
    wait_finish(200, "t6_finish");
    chk("t6_error", o_error, 1);
    chk("t6_reads", o_reads, 3);
    @(negedge clk);
    chk("t6_idle", o_busy, 0);
    chk("t6_sticky", o_error, 1);
    tick();
    err_idx = 0;
    do_start(64'h4000, 64'hC000, 1);
    @(negedge clk);
    chk("t6_err_cleared", o_error, 0);
    tick();

    // Soft reset mid-DRAIN, then a fresh workload.
    clean_reset();
    do_start(64'h6000, 64'hD000, 4);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (n_rd_acc >= 4) begin
          seen = 1;
          break;
        end
      end
      chk("t7_reads_issued", seen, 1);
    end
    tick();
    mmio_rstb = 0;
    tick();
    mmio_rstb = 1;
    @(negedge clk);
    chk("t7_rd_valid", o_rd_req_valid, 0);
    chk("t7_rd_addr", o_rd_req_addr, 0);
    chk("t7_wr_addr", o_wr_req_addr, 0);
    chk("t7_counts", {o_reads, o_writes}, 0);
    chk("t7_flags", {o_busy, o_finish, o_error, o_wr_req_valid, o_dp_result_ready}, 0);
    tick();
    do_start(64'h7000, 64'hE000, 2);
    wait_finish(100, "t7_finish");
    chk("t7_new_reads", o_reads, 2);
    chk("t7_new_writes", o_writes, 2);
    chk("t7_new_addr", (rd_addr_log.size() == 2) ? rd_addr_log[1] : 64'hdead, 64'h7080);
    tick();

    // Credit limit: responses withheld, 16 reads then stop; one rsp frees one.
    clean_reset();
    auto_rsp = 0;
    do_start(64'h10000, 64'h20000, 40);
    repeat (30) tick();
    chk("t2_sixteen", n_rd_acc, 16);
    @(negedge clk);
    chk("t2_blocked", o_rd_req_valid, 0);
    tick();
    force_req++;
    repeat (6) tick();
    chk("t2_one_more", n_rd_acc, 17);
    @(negedge clk);
    chk("t2_blocked_again", o_rd_req_valid, 0);
    tick();
    auto_rsp = 1;
    clean_reset();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
